// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit multiplexed seven-segment scanner.
package display_pkg;

  typedef enum logic [1:0] {
    LEFT_ON  = 2'd0,
    BLANK_L  = 2'd1,
    RIGHT_ON = 2'd2,
    BLANK_R  = 2'd3
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam int LEFT  = 1;
  localparam int RIGHT = 0;

endpackage

// File: rtl/display_scan_timer.sv
// Phase counter: counts to CLK_DIV in lit phases or BLANK_CYC in dark phases, flags the last cycle.
module scan_timer #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic on_sel,
  output logic tc
);

  localparam int MAXC = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] ON_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == (on_sel ? ON_LAST : BLK_LAST));

  // Terminal count wraps to zero, so the counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/display_scan.sv
// Two-digit seven-segment scanner with blanking gaps between digit phases and registered outputs.
module display_scan
  import display_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYC      = 16,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] dse,
  input  logic [6:0] dsd,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       phase_tick
);

  generate
    if (CLK_DIV < 2 || BLANK_CYC < 1) begin : g_bad_params
      $error("display_scan: CLK_DIV must be >= 2 and BLANK_CYC >= 1");
    end
  endgenerate

  localparam logic [1:0] AN_LEFT  = 2'b01 << LEFT;
  localparam logic [1:0] AN_RIGHT = 2'b01 << RIGHT;

  function automatic logic [6:0] seg_pol(input logic [6:0] p);
    return (SEG_ACTIVE_LOW != 0) ? ~p : p;
  endfunction

  function automatic logic [1:0] an_pol(input logic [1:0] lit);
    return (AN_ACTIVE_LOW != 0) ? ~lit : lit;
  endfunction

  scan_state_e state, nxt_state;
  logic        on_sel, tc;
  logic [6:0]  shadow_l, shadow_r;

  assign on_sel = (state == LEFT_ON) || (state == RIGHT_ON);

  scan_timer #(
    .CLK_DIV  (CLK_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .on_sel(on_sel),
    .tc    (tc)
  );

  always_comb begin
    nxt_state = state;
    case (state)
      LEFT_ON:  nxt_state = BLANK_L;
      BLANK_L:  nxt_state = RIGHT_ON;
      RIGHT_ON: nxt_state = BLANK_R;
      BLANK_R:  nxt_state = LEFT_ON;
      default:  nxt_state = BLANK_R;
    endcase
  end

  // Outputs are loaded from the next state so they change on the transition edge itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BLANK_R;
      shadow_l   <= SEG_OFF;
      shadow_r   <= SEG_OFF;
      seg        <= seg_pol(SEG_OFF);
      an         <= an_pol(2'b00);
      phase_tick <= 1'b0;
    end else begin
      phase_tick <= 1'b0;
      if (tc) begin
        state <= nxt_state;
        case (nxt_state)
          LEFT_ON: begin
            shadow_l   <= dse;
            seg        <= seg_pol(dse);
            an         <= an_pol(AN_LEFT);
            phase_tick <= 1'b1;
          end
          RIGHT_ON: begin
            shadow_r   <= dsd;
            seg        <= seg_pol(dsd);
            an         <= an_pol(AN_RIGHT);
            phase_tick <= 1'b1;
          end
          default: begin
            seg <= seg_pol(SEG_OFF);
            an  <= an_pol(2'b00);
          end
        endcase
      end else begin
        // Mid-phase the digit is driven only from its shadow, never from the live inputs.
        case (state)
          LEFT_ON:  seg <= seg_pol(shadow_l);
          RIGHT_ON: seg <= seg_pol(shadow_r);
          default:  seg <= seg_pol(SEG_OFF);
        endcase
      end
    end
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter CLK_DIV, default 50000, clock cycles each digit is lit per scan.
REQ-002 Parameter BLANK_CYC, default 16, clock cycles all digits are dark between digit phases (anti-ghosting).
REQ-003 Parameter SEG_ACTIVE_LOW, default 0, 1 inverts seg so that lit = 0.
REQ-004 Parameter AN_ACTIVE_LOW, default 1, 1 makes an enables active-low.
REQ-005 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Port dse, input, 7, left (tens) digit segment pattern, bit6 = segment a ... bit0 = segment g, 1 = lit.
REQ-008 Port dsd, input, 7, right (units) digit pattern, same encoding as dse.
REQ-009 Port seg, output, 7, shared segment bus to both digits, polarity per SEG_ACTIVE_LOW.
REQ-010 Port an, output, 2, digit enables: an[1] = left, an[0] = right, polarity per AN_ACTIVE_LOW.
REQ-011 Port phase_tick, output, 1, one-cycle pulse on the cycle a digit becomes lit.

Function
REQ-012 The FSM SHALL have four states, cycled in order: LEFT_ON -> BLANK_L -> RIGHT_ON -> BLANK_R -> LEFT_ON.
REQ-013 One down-counter or up-counter SHALL time each state: CLK_DIV cycles in the ON states, BLANK_CYC cycles in the BLANK states.
REQ-014 The counter SHALL clear to 0 on every state transition and SHALL never exceed the limit minus 1.
REQ-015 Counter width SHALL be $clog2 of max(CLK_DIV, BLANK_CYC).
REQ-016 The scan period SHALL be exactly 2*(CLK_DIV+BLANK_CYC) cycles.
REQ-017 On the edge that enters LEFT_ON, dse SHALL be captured into a shadow register.
REQ-018 On the edge that enters RIGHT_ON, dsd SHALL be captured into a shadow register.
REQ-019 Changes on dse/dsd during a lit phase SHALL NOT alter seg until the next capture.
REQ-020 seg and an SHALL be registered and update on the same edge as the state transition, giving no combinational path from inputs to outputs.
REQ-021 In LEFT_ON, seg = left shadow and only the left enable is asserted.
REQ-022 In RIGHT_ON, seg = right shadow and only the right enable is asserted.
REQ-023 In BLANK states, seg = all segments off and both enables are deasserted.
REQ-024 Both enables SHALL never be asserted in the same cycle.
REQ-025 A pattern of 7'b0000000 SHALL still run the full phase timing, with the digit remaining dark.
REQ-026 phase_tick SHALL be registered and high for exactly the first cycle of LEFT_ON and of RIGHT_ON.
REQ-027 Legal parameter values SHALL be CLK_DIV >= 2 and BLANK_CYC >= 1; other values are unsupported and SHALL be flagged by an elaboration-time check.

Reset
REQ-028 While reset = 1 at a rising clk edge, the block SHALL set state = BLANK_R, counter = 0, both shadows = 0, seg = off, an = both off and phase_tick = 0.
REQ-029 Reset SHALL override any in-progress phase, including mid-LEFT_ON.
REQ-030 After reset deasserts, the block SHALL spend BLANK_CYC cycles in BLANK_R, then enter LEFT_ON.

Structure
REQ-031 A shared package display_pkg SHALL hold the state enum, the constant SEG_OFF = 7'b0000000 and the digit index constants LEFT = 1 and RIGHT = 0.
REQ-032 One sub-module, scan_timer, is natural: the parameterised phase counter with limit select and terminal-count output.
REQ-033 All remaining logic SHALL be flat in display_scan.

Verification
Bench parameters: CLK_DIV=4, BLANK_CYC=2, default polarities.
REQ-034 Reset for 3 cycles then release -> an=2'b11 and seg=0 for 2 cycles; then an=2'b01, seg=dse for 4 cycles, with phase_tick high in the first of those cycles.
REQ-035 dse=7'b0110000, dsd=7'b1101101 held -> after release, seg alternates 0110000 (an=01) / 0 / 1101101 (an=10) / 0 with a period of 12 cycles.
REQ-036 Change dsd from 7'b1111110 to 7'b1111001 mid-RIGHT_ON -> seg stays 1111110 until the next RIGHT_ON entry, then shows 1111001.
REQ-037 Assert reset in the 2nd cycle of LEFT_ON -> next edge seg=0, an=11, state BLANK_R; the sequence then restarts per REQ-034.
REQ-038 SEG_ACTIVE_LOW=1, dse=7'b1111110 -> seg=7'b0000001 in LEFT_ON and seg=7'b1111111 in BLANK states.
REQ-039 Run 1000 cycles with random inputs -> assertion never sees both enables active, and phase_tick count equals 2 per 12 cycles.
